// File: rtl/div_8_9.sv
// Dual-modulus /8 or /9 prescaler: a /4-or-/5 counter stage feeding a /2 stage.
// MC is sampled once per output period, on the edge that enters the low half,
// and selects whether that low half lasts 4 or 5 cycles.
// Both stage clocks leave through flops, so they are glitch-free and have no
// combinational path from any input.
module div_8_9 (
   input  logic clk,
   input  logic rst_n,   // active-high synchronous reset despite the name
   input  logic MC,      // 0 = /8, 1 = /9
   output logic f45,
   output logic f89
);

   // High half of the /2 stage (f89 high) and low half (f89 low, optionally stretched)
   typedef enum logic {PH_HI, PH_LO} phase_t;

   phase_t     phase, phase_nx;
   logic [2:0] c45, c45_nx;
   logic [2:0] last;
   logic       wrap;
   logic       mc_q, mc_nx;
   logic       f45_nx, f89_nx;

   // State register: counters, latched modulus and the registered output clocks
   always_ff @(posedge clk) begin
      if (rst_n) begin
         c45   <= '0;
         phase <= PH_HI;
         mc_q  <= 1'b0;
         f45   <= 1'b0;
         f89   <= 1'b0;
      end else begin
         c45   <= c45_nx;
         phase <= phase_nx;
         mc_q  <= mc_nx;
         f45   <= f45_nx;
         f89   <= f89_nx;
      end
   end

   // Next state: /4 or /5 count, /2 toggle on wrap, MC captured entering the low half
   always_comb begin
      last     = (phase == PH_LO && mc_q) ? 3'd4 : 3'd3;
      // >= rather than == so an out-of-range count (e.g. 4 while dividing by 4) still wraps
      wrap     = (c45 >= last);
      c45_nx   = c45 + 3'd1;
      phase_nx = phase;
      mc_nx    = mc_q;
      if (wrap) begin
         c45_nx   = '0;
         phase_nx = (phase == PH_HI) ? PH_LO : PH_HI;
      end
      if (phase == PH_HI && c45 == 3'd3)
         mc_nx = MC;
   end

   // Output decode from current state, registered one cycle later
   always_comb begin
      f45_nx = (c45 < 3'd2);
      f89_nx = (phase == PH_HI);
   end

endmodule

// File: tb/tb_div_8_9.sv
// Directed bench for div_8_9: a waveform-level reference model pushes the
// expected {f45,f89} for each edge into a queue, which is popped and compared
// after the edge. f89 rising edges are also counted and spaced.
module tb_div_8_9;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic MC    = 1'b0;
   logic f45;
   logic f89;

   always #5 clk = ~clk;

   div_8_9 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .MC    (MC),
      .f45   (f45),
      .f89   (f89)
   );

   int n_assert = 0;
   int n_fail   = 0;

   logic [1:0] exp_q[$];

   // Reference model: position inside the current f89 period and its length
   int pos = 0;
   int len = 8;

   // Edge tracking
   logic prev_f89  = 1'b0;
   int   rises     = 0;
   int   last_rise = -1;
   int   cyc       = 0;
   int   want_gap  = 0;   // 0 means 8 or 9 both acceptable

   task automatic check_bits(input string tag, input logic [1:0] got, input logic [1:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s cycle %0d: observed {f45,f89}=%b expected %b", tag, cyc, got, exp);
      end
   endtask

   task automatic check_int(input string tag, input int got, input int exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   task automatic reset_track();
      rises     = 0;
      last_rise = -1;
   endtask

   // One clock edge: drive inputs, predict, then compare after the edge
   task automatic step(input logic r, input logic m, input string tag);
      logic [1:0] e;
      logic [1:0] got;
      int         gap;
      @(negedge clk);
      rst_n = r;
      MC    = m;
      if (r) begin
         e   = 2'b00;
         pos = 0;
         len = 8;
      end else begin
         e[0] = (pos < 4);
         e[1] = (pos < 4) ? (pos < 2) : ((pos - 4) < 2);
         if (pos == 3) len = m ? 9 : 8;
         pos = (pos + 1 == len) ? 0 : pos + 1;
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      cyc++;
      got = {f45, f89};
      check_bits(tag, got, exp_q.pop_front());
      if (f89 && !prev_f89) begin
         if (last_rise >= 0) begin
            gap = cyc - last_rise;
            if (want_gap != 0) check_int({tag, "_gap"}, gap, want_gap);
            else               check_int({tag, "_gap89"}, int'(gap == 8 || gap == 9), 1);
         end
         rises++;
         last_rise = cyc;
      end
      prev_f89 = f89;
   endtask

   initial begin
      // Reset hold
      step(1'b1, 1'b0, "reset_hold");
      step(1'b1, 1'b0, "reset_hold");

      // Steady /8
      reset_track();
      want_gap = 8;
      for (int i = 0; i < 100; i++) step(1'b0, 1'b0, "mc0");
      check_int("mc0_rises", rises, 13);

      // Steady /9 from a fresh reset
      step(1'b1, 1'b1, "reset_mc1");
      reset_track();
      want_gap = 9;
      for (int i = 0; i < 100; i++) step(1'b0, 1'b1, "mc1");
      check_int("mc1_rises", rises, 12);

      // Switch 0 -> 1 at an arbitrary cycle
      step(1'b1, 1'b0, "reset_sw");
      reset_track();
      want_gap = 0;
      for (int i = 0; i < 37; i++) step(1'b0, 1'b0, "sw_mc0");
      for (int i = 0; i < 60; i++) step(1'b0, 1'b1, "sw_mc1");

      // MC raised during a low half: that period stays 8, later ones become 9
      step(1'b1, 1'b0, "reset_tog");
      reset_track();
      for (int i = 0; i < 13; i++) step(1'b0, 1'b0, "tog_mc0");
      for (int i = 0; i < 30; i++) step(1'b0, 1'b1, "tog_mc1");
      // Drop MC again during a low half of a /9 period
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, "tog_back");

      // Reset mid-period during the f89 low half with MC=1
      step(1'b1, 1'b1, "reset_mid_pre");
      reset_track();
      for (int i = 0; i < 15; i++) step(1'b0, 1'b1, "mid_run");
      step(1'b1, 1'b1, "reset_mid");
      step(1'b1, 1'b1, "reset_mid");
      reset_track();
      want_gap = 9;
      for (int i = 0; i < 30; i++) step(1'b0, 1'b1, "after_mid");
      check_int("after_mid_rises", rises, 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
